// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions for the instruction decode stage.
//   - opcode constants for the supported instruction subset
//   - instruction field bit positions
//   - decode-stage FSM state type
//   - decoded control bundle and the opcode decoder that fills it
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } id_state_e;

  // known:    opcode belongs to the supported set (NOP counts as known)
  // valid:    instruction occupies a real ID/EX slot (false for NOP/illegal)
  // reads_rt: the rt field is a source operand, not a destination
  // rd_dest:  destination is rd rather than rt
  typedef struct packed {
    logic known;
    logic valid;
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic reads_rt;
    logic rd_dest;
  } dec_t;

  function automatic dec_t decode_ins(input logic [31:0] ins);
    dec_t d;
    d       = '0;
    d.known = 1'b1;
    d.valid = 1'b1;
    case (ins[OPC_HI:OPC_LO])
      OP_RTYPE: begin
        d.reg_wr   = 1'b1;
        d.rd_dest  = 1'b1;
        d.reads_rt = 1'b1;
      end
      OP_ADDI: d.reg_wr = 1'b1;
      OP_LW: begin
        d.reg_wr = 1'b1;
        d.mem_rd = 1'b1;
      end
      OP_SW: begin
        d.mem_wr   = 1'b1;
        d.reads_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: d.reads_rt = 1'b1;
      OP_J: ;
      default: begin
        d.known = 1'b0;
        d.valid = 1'b0;
      end
    endcase
    // All-zero word is the canonical NOP: a legal bubble.
    if (ins == 32'h0) begin
      d       = '0;
      d.known = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/instruction_decode_block_hazard.sv
// Load-use hazard compare for the decode stage.
//   ex_valid, ex_mem_rd, ex_rt : load currently sitting in ID/EX
//   rs_addr, rt_addr           : source fields of the instruction in decode
//   reads_rt                   : decode instruction uses rt as a source
//   hazard                     : the decode instruction needs the load's result
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       reads_rt,
  output logic       hazard
);

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard = ex_valid & ex_mem_rd & (ex_rt != 5'd0) &
                  ((ex_rt == rs_addr) | (reads_rt & (ex_rt == rt_addr)));

endmodule

// File: rtl/instruction_decode_block.sv
// Decode stage: decodes the fetched instruction, resolves J/BEQ/BNE in the
// decode cycle (zero-penalty redirect of the fetch unit), detects load-use
// hazards and registers the decoded instruction into the ID/EX register.
//   clk, reset (async, active-low)
//   ins, current_address     : fetch stream (ins belongs to last cycle's address)
//   rs_fwd, rt_fwd           : forwarded operands for the branch compare
//   rs_addr, rt_addr         : register-file read addresses (combinational)
//   jmp_loc, pc_mux_sel      : redirect target and select toward fetch
//   stall, stall_pm          : fetch hold / program-memory re-present
//   ex_*                     : ID/EX pipeline register
//   ill_op                   : one-cycle pulse after an unknown opcode
//   state_dbg                : current decode FSM state
//
// Fetch interface: when stall/stall_pm are high the fetch unit keeps its
// address and re-presents the same instruction next cycle; that cycle is the
// STALL state and the instruction is decoded again with the load resolved.
// pc_mux_sel high means the fetch unit presents jmp_loc to memory this cycle,
// so the next ins is the target instruction.
module instruction_decode_block
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic [ADDR_W-1:0] current_address,
  input  logic [DATA_W-1:0] rs_fwd,
  input  logic [DATA_W-1:0] rt_fwd,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              stall,
  output logic              stall_pm,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_wr,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [ADDR_W-1:0] ex_pc,
  output logic              ill_op,
  output id_state_e         state_dbg
);

  id_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ins_pc;
  dec_t              dec;
  logic [5:0]        opcode;
  logic [15:0]       imm16;
  logic [4:0]        dest;
  logic              hazard_raw;
  logic              hazard;
  logic              resolve;
  logic              load_bubble;
  logic              br_taken;

  assign dec       = decode_ins(ins);
  assign opcode    = ins[OPC_HI:OPC_LO];
  assign imm16     = ins[IMM_HI:IMM_LO];
  assign rs_addr   = ins[RS_HI:RS_LO];
  assign rt_addr   = ins[RT_HI:RT_LO];
  assign dest      = !dec.reg_wr ? 5'd0 :
                     (dec.rd_dest ? ins[RD_HI:RD_LO] : ins[RT_HI:RT_LO]);
  assign state_dbg = state;

  hazard_detect u_hazard (
    .ex_valid  (ex_valid),
    .ex_mem_rd (ex_mem_rd),
    .ex_rt     (ex_rt),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .reads_rt  (dec.reads_rt),
    .hazard    (hazard_raw)
  );

  // Unknown opcodes have no meaningful source fields, so they never stall.
  assign hazard = hazard_raw & dec.known;

  assign br_taken = ((opcode == OP_BEQ) & (rs_fwd == rt_fwd)) |
                    ((opcode == OP_BNE) & (rs_fwd != rt_fwd));

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    stall_pm    = 1'b0;
    pc_mux_sel  = 1'b0;
    jmp_loc     = '0;
    load_bubble = 1'b0;
    resolve     = 1'b0;
    // Control outputs stay quiet while reset is held, whatever ins shows.
    if (reset) begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall       = 1'b1;
            stall_pm    = 1'b1;
            load_bubble = 1'b1;
            state_nxt   = STALL;
          end else begin
            resolve = 1'b1;
          end
        end
        STALL: begin
          // ID/EX now holds a bubble, so the re-presented instruction
          // cannot hazard again.
          resolve   = 1'b1;
          state_nxt = RUN;
        end
      endcase
    end
    if (resolve && dec.known) begin
      if (opcode == OP_J) begin
        pc_mux_sel = 1'b1;
        jmp_loc    = ADDR_W'(imm16);
      end else if (br_taken) begin
        pc_mux_sel = 1'b1;
        // Offset is added as a raw 16-bit value and wraps modulo 2^ADDR_W;
        // a "negative" offset lands correctly through the wrap.
        jmp_loc    = ins_pc + ADDR_W'(1) + ADDR_W'(imm16);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      ins_pc    <= '0;
      ill_op    <= 1'b0;
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_funct  <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dest   <= '0;
      ex_imm    <= '0;
      ex_reg_wr <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_pc     <= '0;
    end else begin
      state  <= state_nxt;
      ins_pc <= current_address;
      ill_op <= ~dec.known;
      if (load_bubble || !dec.valid) begin
        ex_valid  <= 1'b0;
        ex_opcode <= '0;
        ex_funct  <= '0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_dest   <= '0;
        ex_imm    <= '0;
        ex_reg_wr <= 1'b0;
        ex_mem_rd <= 1'b0;
        ex_mem_wr <= 1'b0;
        ex_pc     <= '0;
      end else begin
        ex_valid  <= 1'b1;
        ex_opcode <= opcode;
        ex_funct  <= ins[FUNCT_HI:FUNCT_LO];
        ex_rs     <= rs_addr;
        ex_rt     <= rt_addr;
        ex_dest   <= dest;
        ex_imm    <= {{(DATA_W-16){imm16[15]}}, imm16};
        ex_reg_wr <= dec.reg_wr;
        ex_mem_rd <= dec.mem_rd;
        ex_mem_wr <= dec.mem_wr;
        ex_pc     <= ins_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_block.sv
module tb_instruction_decode_block;
  import mips_defs_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic [31:0] rs_fwd, rt_fwd;
  logic [4:0]  rs_addr, rt_addr;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel, stall, stall_pm;
  logic        ex_valid;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [31:0] ex_imm;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [15:0] ex_pc;
  logic        ill_op;
  id_state_e   state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_decode_block #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .stall(stall), .stall_pm(stall_pm),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_imm(ex_imm),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_pc(ex_pc), .ill_op(ill_op), .state_dbg(state_dbg)
  );

  // ---------------- checker / driver ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [15:0] a,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    ins = i; current_address = a; rs_fwd = r1; rt_fwd = r2;
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] ins;
    logic [15:0] addr;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic        sel;
    logic [15:0] jmp;
    logic        stl;
    logic        v;
    logic [4:0]  dest;
    logic        mrd;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] i, input logic [15:0] a, input logic [31:0] r1,
                     input logic [31:0] r2, input logic sel, input logic [15:0] jmp,
                     input logic stl, input logic v, input logic [4:0] dest,
                     input logic mrd, input logic ill);
    vec_t t;
    t.ins = i; t.addr = a; t.rsv = r1; t.rtv = r2; t.sel = sel; t.jmp = jmp;
    t.stl = stl; t.v = v; t.dest = dest; t.mrd = mrd; t.ill = ill;
    vecs.push_back(t);
  endtask

  // ---------------- reference model ----------------
  // Tracks only what the rules need: the last thing placed in ID/EX and the
  // address of the instruction currently being decoded.
  logic        m_v, m_regwr, m_mrd, m_mwr, m_ill;
  logic [5:0]  m_op, m_funct;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [31:0] m_imm;
  logic [15:0] m_epc, m_pc;
  logic        m_stall;

  task automatic model_reset();
    m_v = 0; m_regwr = 0; m_mrd = 0; m_mwr = 0; m_ill = 0;
    m_op = 0; m_funct = 0; m_rs = 0; m_rt = 0; m_dest = 0;
    m_imm = 0; m_epc = 0; m_pc = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic [31:0] i, input logic [15:0] a,
                            input logic [31:0] r1, input logic [31:0] r2);
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        known, nop, reads_rt, hz, x_sel;
    logic [15:0] x_jmp;
    op = i[31:26]; rs = i[25:21]; rt = i[20:16]; rd = i[15:11]; imm = i[15:0];
    known    = op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    nop      = (i == 32'h0);
    reads_rt = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    hz = known && m_v && m_mrd && (m_rt != 0) &&
         ((m_rt == rs) || (reads_rt && (m_rt == rt)));
    x_sel = 0; x_jmp = 0;
    if (known && !hz) begin
      if (op == OP_J) begin
        x_sel = 1; x_jmp = imm;
      end else if ((op == OP_BEQ && r1 == r2) || (op == OP_BNE && r1 != r2)) begin
        x_sel = 1; x_jmp = 16'((32'(m_pc) + 1 + 32'(imm)) % 65536);
      end
    end
    chk("rnd.rs_addr", 32'(rs_addr), 32'(rs));
    chk("rnd.rt_addr", 32'(rt_addr), 32'(rt));
    chk("rnd.pc_mux_sel", 32'(pc_mux_sel), 32'(x_sel));
    chk("rnd.jmp_loc", 32'(jmp_loc), 32'(x_jmp));
    chk("rnd.stall", 32'(stall), 32'(hz));
    chk("rnd.stall_pm", 32'(stall_pm), 32'(hz));
    m_stall = hz;
    // ID/EX contents after the edge
    m_ill = !known;
    if (hz || !known || nop) begin
      m_v = 0; m_regwr = 0; m_mrd = 0; m_mwr = 0; m_op = 0; m_funct = 0;
      m_rs = 0; m_rt = 0; m_dest = 0; m_imm = 0; m_epc = 0;
    end else begin
      m_v = 1; m_op = op; m_funct = i[5:0]; m_rs = rs; m_rt = rt;
      m_imm = {{16{imm[15]}}, imm}; m_epc = m_pc;
      m_regwr = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW);
      m_mrd = (op == OP_LW);
      m_mwr = (op == OP_SW);
      m_dest = (op == OP_RTYPE) ? rd : ((op == OP_ADDI || op == OP_LW) ? rt : 5'd0);
    end
    m_pc = a;
  endtask

  task automatic check_ex();
    chk("rnd.ex_valid", 32'(ex_valid), 32'(m_v));
    chk("rnd.ex_opcode", 32'(ex_opcode), 32'(m_op));
    chk("rnd.ex_funct", 32'(ex_funct), 32'(m_funct));
    chk("rnd.ex_rs", 32'(ex_rs), 32'(m_rs));
    chk("rnd.ex_rt", 32'(ex_rt), 32'(m_rt));
    chk("rnd.ex_dest", 32'(ex_dest), 32'(m_dest));
    chk("rnd.ex_imm", ex_imm, m_imm);
    chk("rnd.ex_reg_wr", 32'(ex_reg_wr), 32'(m_regwr));
    chk("rnd.ex_mem_rd", 32'(ex_mem_rd), 32'(m_mrd));
    chk("rnd.ex_mem_wr", 32'(ex_mem_wr), 32'(m_mwr));
    chk("rnd.ex_pc", 32'(ex_pc), 32'(m_epc));
    chk("rnd.ill_op", 32'(ill_op), 32'(m_ill));
  endtask

  function automatic logic [31:0] gen_ins();
    logic [5:0] op;
    int k;
    k = $urandom_range(0, 10);
    case (k)
      0, 1:    op = OP_LW;
      2:       op = OP_RTYPE;
      3:       op = OP_ADDI;
      4:       op = OP_SW;
      5:       op = OP_BEQ;
      6:       op = OP_BNE;
      7:       op = OP_J;
      8:       op = 6'h3F;
      9:       op = 6'h01;
      default: return 32'h0;
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] cur;
    reset = 1'b0; ins = 32'h8C220004; current_address = 16'h0;
    rs_fwd = 0; rt_fwd = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ex_valid", 32'(ex_valid), 0);
    chk("rst.ex_mem_rd", 32'(ex_mem_rd), 0);
    chk("rst.ex_dest", 32'(ex_dest), 0);
    chk("rst.ex_imm", ex_imm, 0);
    chk("rst.ex_reg_wr", 32'(ex_reg_wr), 0);
    chk("rst.ex_pc", 32'(ex_pc), 0);
    chk("rst.ill_op", 32'(ill_op), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.stall_pm", 32'(stall_pm), 0);
    chk("rst.pc_mux_sel", 32'(pc_mux_sel), 0);
    chk("rst.state", 32'(state_dbg), 32'(RUN));
    ins = 32'h08000040;
    #1;
    chk("rst.j_sel_masked", 32'(pc_mux_sel), 0);
    chk("rst.j_jmp_masked", 32'(jmp_loc), 0);

    @(negedge clk);
    ins = 32'h8C220004; current_address = 16'h0004; reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.lw_valid", 32'(ex_valid), 1);
    chk("rst.lw_mem_rd", 32'(ex_mem_rd), 1);
    chk("rst.lw_dest", 32'(ex_dest), 2);
    chk("rst.lw_reg_wr", 32'(ex_reg_wr), 1);
    chk("rst.lw_imm", ex_imm, 32'h4);

    // Directed table (rows run back to back; ins_pc = previous row's addr)
    add(32'h00000000, 16'h0005, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(32'h08000040, 16'h0040, 0, 0, 1, 16'h0040, 0, 1, 0, 0, 0);
    add(32'h10000000, 16'h0010, 0, 0, 1, 16'h0041, 0, 1, 0, 0, 0);
    add(32'h10220003, 16'h0010, 7, 7, 1, 16'h0014, 0, 1, 0, 0, 0);
    add(32'h10220003, 16'h0020, 7, 8, 0, 16'h0000, 0, 1, 0, 0, 0);
    add(32'h1422FFFE, 16'h0000, 7, 8, 1, 16'h001F, 0, 1, 0, 0, 0);
    add(32'h14220000, 16'hFFFF, 5, 5, 0, 16'h0000, 0, 1, 0, 0, 0);
    add(32'h10000001, 16'h0030, 0, 0, 1, 16'h0001, 0, 1, 0, 0, 0);
    add(32'h8C220004, 16'h0031, 0, 0, 0, 16'h0000, 0, 1, 2, 1, 0);
    add(32'h00441820, 16'h0031, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0);
    add(32'h00441820, 16'h0032, 0, 0, 0, 16'h0000, 0, 1, 3, 0, 0);
    add(32'h8C200004, 16'h0033, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 0);
    add(32'h00041820, 16'h0034, 0, 0, 0, 16'h0000, 0, 1, 3, 0, 0);
    add(32'h8C410000, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 0);
    add(32'h1025FFFF, 16'h0000, 9, 9, 0, 16'h0000, 1, 0, 0, 0, 0);
    add(32'h1025FFFF, 16'h0050, 9, 9, 1, 16'h0000, 0, 1, 0, 0, 0);
    add(32'hFC000000, 16'h0051, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    add(32'h00000000, 16'h0052, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(32'h20A70005, 16'h0053, 0, 0, 0, 16'h0000, 0, 1, 7, 0, 0);
    add(32'h8C220000, 16'h0054, 0, 0, 0, 16'h0000, 0, 1, 2, 1, 0);
    add(32'h20620001, 16'h0055, 0, 0, 0, 16'h0000, 0, 1, 2, 0, 0);
    add(32'h8C220000, 16'h0056, 0, 0, 0, 16'h0000, 0, 1, 2, 1, 0);
    add(32'hAC620008, 16'h0056, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0);
    add(32'hAC620008, 16'h0057, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    add(32'h8C220000, 16'h0058, 0, 0, 0, 16'h0000, 0, 1, 2, 1, 0);
    add(32'hFC400000, 16'h0059, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    add(32'h00000000, 16'h005A, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].ins, vecs[k].addr, vecs[k].rsv, vecs[k].rtv);
      chk($sformatf("row%0d.pc_mux_sel", k), 32'(pc_mux_sel), 32'(vecs[k].sel));
      chk($sformatf("row%0d.jmp_loc", k), 32'(jmp_loc), 32'(vecs[k].jmp));
      chk($sformatf("row%0d.stall", k), 32'(stall), 32'(vecs[k].stl));
      chk($sformatf("row%0d.stall_pm", k), 32'(stall_pm), 32'(vecs[k].stl));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d.ex_valid", k), 32'(ex_valid), 32'(vecs[k].v));
      chk($sformatf("row%0d.ex_dest", k), 32'(ex_dest), 32'(vecs[k].dest));
      chk($sformatf("row%0d.ex_mem_rd", k), 32'(ex_mem_rd), 32'(vecs[k].mrd));
      chk($sformatf("row%0d.ill_op", k), 32'(ill_op), 32'(vecs[k].ill));
    end

    // Reset in the middle of a stall
    drive(32'h8C220000, 16'h0060, 0, 0);
    @(posedge clk);
    drive(32'h00441820, 16'h0060, 0, 0);
    chk("rms.stall", 32'(stall), 1);
    chk("rms.state_run", 32'(state_dbg), 32'(RUN));
    @(posedge clk);
    #1;
    chk("rms.state_stall", 32'(state_dbg), 32'(STALL));
    chk("rms.bubble", 32'(ex_valid), 0);
    #2;
    reset = 1'b0;
    #1;
    chk("rms.state_after", 32'(state_dbg), 32'(RUN));
    chk("rms.ex_valid", 32'(ex_valid), 0);
    chk("rms.stall_held", 32'(stall), 0);
    ins = 32'h08000040;
    #1;
    chk("rms.sel_held", 32'(pc_mux_sel), 0);
    @(negedge clk);
    reset = 1'b1; ins = 32'h00441820;
    #1;
    chk("rms.no_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    chk("rms.add_valid", 32'(ex_valid), 1);
    chk("rms.add_dest", 32'(ex_dest), 3);

    // Randomized run against the model, from a fresh reset
    @(negedge clk);
    reset = 1'b0; ins = 32'h0; current_address = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cur = 32'h0;
    for (int n = 0; n < 400; n++) begin
      // A stalled instruction is re-presented, as the fetch unit would.
      if (!m_stall) cur = gen_ins();
      drive(cur, 16'($urandom), 32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)));
      model_step(cur, current_address, rs_fwd, rt_fwd);
      @(posedge clk);
      #1;
      check_ex();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
